// File: rtl/mux_rr_n_pkg.sv
// Shared constants and helpers for the N-way registered selector and its bench.
package mux_rr_n_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Lowest bit of channel k inside a flattened bus of width-bit channels.
  function automatic int chan_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/mux_rr_n_arbiter.sv
// Grant selection for mux_rr_n: fixed index or rotating-priority search from ptr.
// ptr only advances on an accepted round-robin grant, pointing just past the winner.
module rr_arbiter
  import mux_rr_n_pkg::*;
#(
  parameter int N     = 32,
  parameter int IDX_W = clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  input  logic             fixed_en_i,
  input  logic [IDX_W-1:0] fixed_idx_i,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin : grant_sel
    int cand;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = 0;
    if (fixed_en_i) begin
      for (int k = 0; k < N; k++) begin
        if (fixed_idx_i == IDX_W'(k) && req_i[k]) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o   = IDX_W'(k);
        end
      end
    end else begin
      // Walk from lowest to highest priority so the last hit is the winner.
      for (int i = N - 1; i >= 0; i--) begin
        cand = int'(ptr_q) + i;
        if (cand >= N) cand = cand - N;
        if (req_i[cand]) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o   = IDX_W'(cand);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && !fixed_en_i && gnt_valid_o) begin
      ptr_d = (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-way registered selector, fixed-select or round-robin, one output register stage.
// Latency 1 cycle; a stalled output register holds its beat and drops every in_ready.
module mux_rr_n
  import mux_rr_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int SEL_W = clog2(N)
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   select_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [N-1:0]       in_valid_i,
  output logic [N-1:0]       in_ready_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SEL_W-1:0]   out_sel_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  logic             load;
  logic             xfer;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  assign load = !out_valid_q || out_ready_i;
  // Reset gating keeps in_ready low even though load is high with an empty register.
  assign xfer = load && gnt_valid && reset_ni;

  rr_arbiter #(
    .N     (N),
    .IDX_W (SEL_W)
  ) u_arb (
    .clk_i       (clock_i),
    .rst_ni      (reset_ni),
    .req_i       (in_valid_i),
    .advance_i   (load),
    .fixed_en_i  (mode_i == MODE_FIXED),
    .fixed_idx_i (select_i),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    in_ready_o = '0;
    gnt_data   = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        in_ready_o[k] = xfer;
        gnt_data      = in_data_i[chan_lsb(k, WIDTH) +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_data_d = gnt_data;
        out_sel_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: a 32-channel and a 5-channel instance share clock and reset.
module tb_mux_rr_n;
  import mux_rr_n_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic         md32, ordy32, ov32;
  logic [4:0]   sel32, os32;
  logic [1023:0] dat32;
  logic [31:0]  vld32, rdy32, exp_rdy32, od32;

  logic         md5, ordy5, ov5;
  logic [2:0]   sel5, os5;
  logic [39:0]  dat5;
  logic [4:0]   vld5, rdy5, exp_rdy5;
  logic [7:0]   od5;

  mux_rr_n #(.WIDTH(32), .N(32)) u32 (
    .clock_i(clk), .reset_ni(rst_n), .mode_i(md32), .select_i(sel32),
    .in_data_i(dat32), .in_valid_i(vld32), .in_ready_o(rdy32),
    .out_data_o(od32), .out_sel_o(os32), .out_valid_o(ov32), .out_ready_i(ordy32)
  );

  mux_rr_n #(.WIDTH(8), .N(5)) u5 (
    .clock_i(clk), .reset_ni(rst_n), .mode_i(md5), .select_i(sel5),
    .in_data_i(dat5), .in_valid_i(vld5), .in_ready_o(rdy5),
    .out_data_o(od5), .out_sel_o(os5), .out_valid_o(ov5), .out_ready_i(ordy5)
  );

  typedef struct {
    int          sel;
    logic [31:0] data;
  } beat_t;

  beat_t q32[$];
  beat_t q5[$];
  int    m32_ptr, m5_ptr;
  logic  m32_vld, m5_vld;

  function automatic int model_grant(input logic md, input int sl, input logic [63:0] v,
                                     input int ptr, input int n);
    if (md == MODE_FIXED) return (sl < n && v[sl]) ? sl : -1;
    for (int i = 0; i < n; i++) begin
      if (v[(ptr + i) % n]) return (ptr + i) % n;
    end
    return -1;
  endfunction

  task automatic reset_models();
    q32.delete(); q5.delete();
    m32_ptr = 0; m5_ptr = 0; m32_vld = 1'b0; m5_vld = 1'b0;
    exp_rdy32 = '0; exp_rdy5 = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Drive one cycle of stimulus and predict the resulting transfer.
  task automatic drive32(input logic md, input logic [4:0] sl, input logic [31:0] v, input logic ordy);
    int g;
    logic ld;
    md32 = md; sel32 = sl; vld32 = v; ordy32 = ordy;
    g  = model_grant(md, int'(sl), 64'(v), m32_ptr, 32);
    ld = !m32_vld || ordy;
    exp_rdy32 = '0;
    if (ld && g >= 0) begin
      exp_rdy32[g] = 1'b1;
      q32.push_back('{sel: g, data: dat32[chan_lsb(g, 32) +: 32]});
      m32_vld = 1'b1;
      if (md == MODE_RR) m32_ptr = (g == 31) ? 0 : g + 1;
    end else if (ld) begin
      m32_vld = 1'b0;
    end
  endtask

  task automatic drive5(input logic md, input logic [2:0] sl, input logic [4:0] v, input logic ordy);
    int g;
    logic ld;
    md5 = md; sel5 = sl; vld5 = v; ordy5 = ordy;
    g  = model_grant(md, int'(sl), 64'(v), m5_ptr, 5);
    ld = !m5_vld || ordy;
    exp_rdy5 = '0;
    if (ld && g >= 0) begin
      exp_rdy5[g] = 1'b1;
      q5.push_back('{sel: g, data: 32'(dat5[chan_lsb(g, 8) +: 8])});
      m5_vld = 1'b1;
      if (md == MODE_RR) m5_ptr = (g == 4) ? 0 : g + 1;
    end else if (ld) begin
      m5_vld = 1'b0;
    end
  endtask

  // Scoreboard pop: a beat leaves when out_valid and out_ready meet at the next edge.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && ov32 && ordy32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL mon32_extra: got unexpected beat sel=%0d data=%h", os32, od32);
      end else begin
        beat_t b;
        b = q32.pop_front();
        if (os32 !== 5'(b.sel) || od32 !== b.data) begin
          errors++;
          $display("FAIL mon32_beat: got sel=%0d data=%h, want sel=%0d data=%h", os32, od32, b.sel, b.data);
        end
      end
    end
    if (rst_n && ov5 && ordy5) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL mon5_extra: got unexpected beat sel=%0d data=%h", os5, od5);
      end else begin
        beat_t b;
        b = q5.pop_front();
        if (os5 !== 3'(b.sel) || od5 !== b.data[7:0]) begin
          errors++;
          $display("FAIL mon5_beat: got sel=%0d data=%h, want sel=%0d data=%h", os5, od5, b.sel, b.data[7:0]);
        end
      end
    end
  end

  task automatic idle_inputs();
    md32 = MODE_FIXED; sel32 = '0; vld32 = '0; ordy32 = 1'b1;
    md5  = MODE_FIXED; sel5  = '0; vld5  = '0; ordy5  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_models();
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    md32 = MODE_RR; vld32 = '1; md5 = MODE_RR; vld5 = '1;
    #1 rst_n = 1'b0;
    reset_models();
    #1;
    checks += 8;
    if (ov32 !== 1'b0)  begin errors++; $display("FAIL reset_ov32: got %b want 0", ov32); end
    if (od32 !== '0)    begin errors++; $display("FAIL reset_od32: got %h want 0", od32); end
    if (os32 !== '0)    begin errors++; $display("FAIL reset_os32: got %0d want 0", os32); end
    if (rdy32 !== '0)   begin errors++; $display("FAIL reset_rdy32: got %h want 0", rdy32); end
    if (ov5 !== 1'b0)   begin errors++; $display("FAIL reset_ov5: got %b want 0", ov5); end
    if (od5 !== '0)     begin errors++; $display("FAIL reset_od5: got %h want 0", od5); end
    if (os5 !== '0)     begin errors++; $display("FAIL reset_os5: got %0d want 0", os5); end
    if (rdy5 !== '0)    begin errors++; $display("FAIL reset_rdy5: got %h want 0", rdy5); end
    do_reset();
  endtask

  task automatic test_fixed_sweep();
    do_reset();
    for (int k = 0; k < 32; k++) dat32[chan_lsb(k, 32) +: 32] = 32'(k);
    for (int s = 0; s < 32; s++) begin
      tick();
      drive32(MODE_FIXED, 5'(s), '1, 1'b1);
      #2;
      checks += 2;
      if (rdy32 !== exp_rdy32 || $countones(rdy32) != 1) begin
        errors++; $display("FAIL sweep_rdy: sel=%0d got %h want %h", s, rdy32, exp_rdy32);
      end
      if (s > 0 && (ov32 !== 1'b1 || od32 !== 32'(s - 1) || os32 !== 5'(s - 1))) begin
        errors++; $display("FAIL sweep_out: step %0d got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                           s, ov32, od32, os32, s - 1, s - 1);
      end
    end
    tick(); drive32(MODE_FIXED, '0, '0, 1'b1);
    tick(); drive32(MODE_FIXED, '0, '0, 1'b1);
    #2;
    checks++;
    if (ov32 !== 1'b0 || os32 !== 5'd31 || q32.size() != 0) begin
      errors++; $display("FAIL sweep_drain: got v=%b s=%0d pending=%0d want v=0 s=31 pending=0", ov32, os32, q32.size());
    end
  endtask

  task automatic test_rr_fairness();
    int ord[6] = '{0, 2, 5, 0, 2, 5};
    do_reset();
    for (int k = 0; k < 32; k++) dat32[chan_lsb(k, 32) +: 32] = $urandom;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive32(MODE_RR, '0, 32'h0000_0025, 1'b1);
      #2;
      checks++;
      if (rdy32 !== (32'd1 << ord[i])) begin
        errors++; $display("FAIL rr_fair: grant %0d got %h want %h", i, rdy32, 32'd1 << ord[i]);
      end
    end
    tick(); drive32(MODE_RR, '0, '0, 1'b1);
    tick(); drive32(MODE_RR, '0, '0, 1'b1);
  endtask

  task automatic test_rr_wrap();
    int ord[4] = '{0, 4, 0, 4};
    do_reset();
    for (int k = 0; k < 5; k++) dat5[chan_lsb(k, 8) +: 8] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      tick();
      drive5(MODE_RR, '0, 5'b10001, 1'b1);
      #2;
      checks++;
      if (rdy5 !== (5'd1 << ord[i])) begin
        errors++; $display("FAIL rr_wrap: grant %0d got %b want %b", i, rdy5, 5'd1 << ord[i]);
      end
    end
    tick(); drive5(MODE_RR, '0, '0, 1'b1);
    tick(); drive5(MODE_RR, '0, '0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    do_reset();
    for (int k = 0; k < 32; k++) dat32[chan_lsb(k, 32) +: 32] = $urandom;
    d0 = dat32[31:0];
    tick(); drive32(MODE_RR, '0, '1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(); drive32(MODE_RR, '0, '1, 1'b0);
      #2;
      checks++;
      if (rdy32 !== '0 || ov32 !== 1'b1 || os32 !== 5'd0 || od32 !== d0) begin
        errors++; $display("FAIL bp_stall: cycle %0d got rdy=%h v=%b s=%0d d=%h want rdy=0 v=1 s=0 d=%h",
                           c, rdy32, ov32, os32, od32, d0);
      end
    end
    tick(); drive32(MODE_RR, '0, '1, 1'b1);
    #2;
    checks++;
    if (rdy32 !== 32'd2) begin errors++; $display("FAIL bp_resume: got rdy=%h want 2", rdy32); end
    tick(); drive32(MODE_RR, '0, '0, 1'b1);
    #2;
    checks++;
    if (os32 !== 5'd1 || od32 !== dat32[63:32]) begin
      errors++; $display("FAIL bp_next: got s=%0d d=%h want s=1 d=%h", os32, od32, dat32[63:32]);
    end
    tick(); drive32(MODE_RR, '0, '0, 1'b1);
    #2;
    checks++;
    if (q32.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d want 0", q32.size()); end
  endtask

  task automatic test_fixed_invalid();
    do_reset();
    for (int k = 0; k < 5; k++) dat5[chan_lsb(k, 8) +: 8] = 8'($urandom);
    tick(); drive5(MODE_FIXED, 3'd2, '1, 1'b1);
    #2;
    checks++;
    if (rdy5 !== 5'b00100) begin errors++; $display("FAIL finv_sel2: got %b want 00100", rdy5); end
    tick(); drive5(MODE_FIXED, 3'd6, '1, 1'b1);
    #2;
    checks++;
    if (rdy5 !== '0 || ov5 !== 1'b1) begin
      errors++; $display("FAIL finv_sel6: got rdy=%b v=%b want rdy=0 v=1", rdy5, ov5);
    end
    tick(); drive5(MODE_FIXED, 3'd3, 5'b10111, 1'b1);
    #2;
    checks++;
    if (rdy5 !== '0 || ov5 !== 1'b0 || os5 !== 3'd2 || od5 !== dat5[23:16]) begin
      errors++; $display("FAIL finv_drain: got rdy=%b v=%b s=%0d d=%h want rdy=0 v=0 s=2 d=%h",
                         rdy5, ov5, os5, od5, dat5[23:16]);
    end
    tick(); drive5(MODE_FIXED, 3'd3, 5'b10111, 1'b1);
    #2;
    checks++;
    if (ov5 !== 1'b0 || q5.size() != 0) begin
      errors++; $display("FAIL finv_novld: got v=%b pending=%0d want v=0 pending=0", ov5, q5.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 32; k++) dat32[chan_lsb(k, 32) +: 32] = $urandom;
    repeat (3) begin
      tick(); drive32(MODE_RR, '0, '1, 1'b1);
    end
    @(posedge clk);
    #2;
    checks++;
    if (ov32 !== 1'b1) begin errors++; $display("FAIL rmid_pre: got v=%b want 1", ov32); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov32 !== 1'b0 || od32 !== '0 || os32 !== '0 || rdy32 !== '0) begin
      errors++; $display("FAIL rmid_async: got v=%b d=%h s=%0d rdy=%h want all 0", ov32, od32, os32, rdy32);
    end
    reset_models();
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 drive32(MODE_RR, '0, 32'hFFFF_FFF8, 1'b1);
    #2;
    checks++;
    if (rdy32 !== 32'd8) begin errors++; $display("FAIL rmid_first: got rdy=%h want 8", rdy32); end
    tick(); drive32(MODE_RR, '0, '0, 1'b1);
    tick(); drive32(MODE_RR, '0, '0, 1'b1);
    #2;
    checks++;
    if (q32.size() != 0 || ov32 !== 1'b0) begin
      errors++; $display("FAIL rmid_drain: got pending=%0d v=%b want 0 0", q32.size(), ov32);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    dat32 = '0;
    dat5  = '0;
    test_reset();
    test_fixed_sweep();
    test_rr_fairness();
    test_rr_wrap();
    test_backpressure();
    test_fixed_invalid();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-way, WIDTH-bit registered selector with a valid/ready handshake per channel. It succeeds the combinational 32:1 ALU result mux.
- Two modes:
  - Fixed mode: the select port chooses the channel, as in the combinational mux.
  - Round-robin mode: arbitration is fair across all valid channels.
- One output register stage provides backpressure. Used in the ALU/writeback path where multiple producers share one result bus.

Parameters:
- WIDTH, 32, data width per channel.
- N, 32, channel count; legal range 2..64; need not be a power of two.
- SEL_W, clog2(N) (5 at default), width of the select and out_sel ports.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Low = reset asserted.
- mode  in  1  0 = fixed select, 1 = round-robin.
- select  in  SEL_W  channel index used in fixed mode.
- in_data  in  N*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit high per cycle.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  index of the channel that out_data came from.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts a beat.

Behaviour:
- Reset (reset low, asynchronous):
  - out_valid = 0, out_data = 0, out_sel = 0, RR pointer = 0.
  - in_ready forced to all zeros while reset is low.
  - Reset mid-transfer drops the held beat, with no partial outputs.
- load = !out_valid | out_ready. The output register accepts a new beat only when load = 1.
- Grant (combinational, evaluated every cycle):
  - Fixed mode: grant = select if select < N and in_valid[select]; otherwise no grant. select >= N never grants.
  - RR mode: grant is the first k with in_valid[k], searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- in_ready[g] = load & granted(g). All other in_ready bits are 0. A transfer on channel g occurs when in_valid[g] & in_ready[g].
- On a transfer, at the next edge:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - In RR mode, ptr <= (g == N-1) ? 0 : g+1.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high.
- Stall (out_valid & !out_ready):
  - out_data and out_sel hold stable.
  - All in_ready bits are 0.
  - ptr holds.
- Drain and refill in the same cycle (out_valid & out_ready & a grant): the new beat replaces the old one, and out_valid stays 1.
- Drain with no grant: out_valid <= 0 at the next edge; out_data and out_sel keep their last values.
- Fixed mode never updates ptr. A mode or select change affects only the next load; a held beat is unaffected.
- in_ready may depend combinationally on in_valid, select, mode and out_ready. in_valid must not depend on in_ready.

Decomposition:
- Shared package holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - a clog2 function.
  - the channel-slice helper, so the bench and the RTL index in_data identically.
- Sub-module rr_arbiter (N parameter), containing:
  - the ptr register.
  - the rotate-priority encoder.
  - inputs: req[N], advance, fixed_en, fixed_idx.
  - outputs: gnt_valid, gnt_idx.
- mux_rr_n contains the ready logic and the output register.

Test Plan:
- Fixed sweep: N=32, WIDTH=32, mode=0, channel k drives data k, all in_valid=1, out_ready=1; step select 0..31 one per cycle. Required response:
  - out_data = k and out_sel = k one cycle later.
  - out_valid stays continuously high.
  - exactly one in_ready bit is high per cycle.
- Round-robin fairness: mode=1, in_valid = 0x0000_0025 (channels 0, 2, 5), out_ready=1. Required grant order: 0, 2, 5, 0, 2, 5, ...
- Round-robin wrap: N=5, in_valid = 5'b10001. Required grant order: 0, 4, 0, 4; ptr wraps from 4 to 0.
- Backpressure: mode=1, all valid, out_ready low for 3 cycles after the first beat. Required response:
  - out_data and out_sel frozen during the stall.
  - in_ready = 0 during the stall.
  - after out_ready rises, the next beat is from channel 1 with no beat lost or duplicated.
- Fixed-mode invalid cases, N=5, mode=0:
  - select = 6 -> no in_ready; out_valid drops after the drain.
  - select = 3 with in_valid[3] = 0 -> no transfer.
- Reset mid-stream: pull reset low asynchronously between clock edges while out_valid=1. Required response:
  - out_valid, out_data and out_sel go to 0 immediately.
  - after release, the first RR grant is the lowest valid channel (ptr = 0).
